dma_multi: RTL and testbench
============================

DMA_MULTI -- requirements
Module: dma_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, meaning number of independent request channels (1..8).
REQ-002 SHALL have parameter AW, default 16, meaning address width.
REQ-003 SHALL have parameter LW, default 8, meaning per-channel length field width.
REQ-004 SHALL have parameter BLK_SHIFT, default 4, meaning the left shift from length units to bytes.
REQ-005 SHALL have port clk  in  1  meaning the single clock, with all logic on its rising edge.
REQ-006 SHALL have port reset  in  1  meaning reset, synchronous and active-high.
REQ-007 SHALL have port rdy  in  1  meaning advance enable, where low freezes the engine.
REQ-008 SHALL have port ctrl  in  CHANNELS  meaning per-channel start level.
REQ-009 SHALL have port src_addr  in  CHANNELS*AW  meaning per-channel source address, with channel n at bits [n*AW +: AW].
REQ-010 SHALL have port dst_addr  in  CHANNELS*AW  meaning per-channel destination address.
REQ-011 SHALL have port length  in  CHANNELS*LW  meaning per-channel length in blocks.
REQ-012 SHALL have port mode  in  CHANNELS*2  meaning 00 copy src->dst, 01 copy dst->src, 10 fill dst, 11 treated as 00.
REQ-013 SHALL have port fill  in  8  meaning the fill byte.
REQ-014 SHALL have port din  in  8  meaning memory read data.
REQ-015 SHALL have port addr  out  AW  meaning the registered memory address.
REQ-016 SHALL have port dout  out  8  meaning the registered write data.
REQ-017 SHALL have port write  out  1  meaning the write strobe, high only in WRITE.
REQ-018 SHALL have port busy  out  CHANNELS  meaning the channel is pending or in service.
REQ-019 SHALL have port done  out  CHANNELS  meaning a one-cycle completion pulse.
REQ-020 SHALL have port active  out  max(1,clog2(CHANNELS))  meaning the index of the channel in service.

Function
REQ-021 SHALL set pending[n] on a ctrl[n] rising edge (high now, low previous clk) when busy[n]=0; edges while busy[n]=1 SHALL be ignored; edge detection SHALL run regardless of rdy.
REQ-022 SHALL implement states IDLE, START, READ, WRITE; the state, counters, addr, dout and write SHALL hold while rdy=0.
REQ-023 SHALL, in IDLE with any pending bit set, grant round-robin starting at (last granted+1) mod CHANNELS, set active, clear the granted pending bit, and go to START.
REQ-024 SHALL, in START, latch rd_ptr/wr_ptr per mode and count = length<<BLK_SHIFT (LW+BLK_SHIFT bits); when count=0 it SHALL pulse done and return to IDLE with no memory access.
REQ-025 SHALL, in READ, drive addr=rd_ptr and write=0, then go to WRITE.
REQ-026 SHALL, in WRITE, drive addr=wr_ptr, write=1, and dout=din as sampled on the edge leaving READ (fill mode: dout=fill).
REQ-027 SHALL, on leaving WRITE, increment the pointers modulo 2^AW (wrap without error) and decrement count; when count reaches 0 it SHALL pulse done[active] and go to IDLE, otherwise go to READ (copy) or stay in WRITE (fill).
REQ-028 SHALL give copy mode 2 rdy cycles per byte and fill mode 1 rdy cycle per byte, with no READ cycles in fill mode.
REQ-029 SHALL keep busy[n] = pending[n] | (state!=IDLE & active==n).
REQ-030 SHALL NOT allow an in-progress transfer to be preempted, and SHALL sample a ctrl edge on the same cycle as done as a new request.

Reset
REQ-031 SHALL, on reset, force state IDLE, clear pending and the edge history, set last granted to CHANNELS-1, and set addr=0, dout=0, write=0, done=0, active=0 and busy=0.
REQ-032 SHALL abort a transfer on reset mid-operation without a done pulse, with write low on the cycle after the reset edge.

Configuration
REQ-033 SHALL compile fill mode in when macro DMA_MULTI_FILL_EN is defined; without it, mode 10 SHALL behave as 00, the fill port SHALL remain but be unused, and the fill path SHALL NOT be synthesised.

Structure
REQ-034 SHALL place the state enum and the MODE_COPY, MODE_SWAP, MODE_FILL constants in shared package dma_pkg.
REQ-035 SHALL implement the round-robin arbiter as sub-module dma_rr_arb (inputs req and last, outputs grant valid and index).

Verification
REQ-036 SHALL cover: ch0 mode 00, src 0x1000, dst 0x2000, length 1, rdy=1 -> 16 reads 0x1000..0x100F, each followed by a write to 0x2000..0x200F with matching data, then done[0] one cycle.
REQ-037 SHALL cover: ch0 and ch1 ctrl rising on the same cycle, both length 1 -> ch0 served fully first, then ch1; repeat -> ch1 is served before ch0.
REQ-038 SHALL cover: mode 10, fill 0xA5, dst 0xFFF8, length 1 -> 16 consecutive write cycles with addr wrapping 0xFFF8..0x0007 and dout=0xA5; with DMA_MULTI_FILL_EN undefined -> copy behaviour instead.
REQ-039 SHALL cover: rdy toggled 1010... during a copy -> identical addr/data sequence, stretched, with no duplicate or lost writes.
REQ-040 SHALL cover: length 0 -> done pulse two cycles after grant and no write; ctrl re-pulsed while busy -> ignored.
REQ-041 SHALL cover: reset asserted at the 5th WRITE -> write=0 next cycle, no done, busy=0, and a fresh request afterwards restarts from the latched addresses.

Source files
------------

// File: rtl/dma_pkg.sv
// dma_pkg: shared FSM states, transfer mode encodings and index-width helper for dma_multi.
package dma_pkg;
  typedef enum logic [1:0] {IDLE, START, READ, WRITE} state_e;
  localparam logic [1:0] MODE_COPY = 2'b00;
  localparam logic [1:0] MODE_SWAP = 2'b01;
  localparam logic [1:0] MODE_FILL = 2'b10;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dma_rr_arb.sv
// dma_rr_arb: round-robin arbiter searching from (last+1) mod N.
module dma_rr_arb
  import dma_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] index
);
  logic [IW-1:0] c;
  // Walk candidates farthest-first so the nearest requester after last wins.
  always_comb begin
    valid = |req;
    index = '0;
    c = '0;
    for (int i = N; i >= 1; i--) begin
      c = IW'((int'(last) + i) % N);
      if (req[c]) index = c;
    end
  end
endmodule

// File: rtl/dma_multi.sv
// dma_multi: multi-channel byte DMA (copy, swap-copy, optional fill when DMA_MULTI_FILL_EN is defined).
module dma_multi
  import dma_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int AW        = 16,
  parameter int LW        = 8,
  parameter int BLK_SHIFT = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rdy,
  input  logic [CHANNELS-1:0]         ctrl,
  input  logic [CHANNELS*AW-1:0]      src_addr,
  input  logic [CHANNELS*AW-1:0]      dst_addr,
  input  logic [CHANNELS*LW-1:0]      length,
  input  logic [CHANNELS*2-1:0]       mode,
  input  logic [7:0]                  fill,
  input  logic [7:0]                  din,
  output logic [AW-1:0]               addr,
  output logic [7:0]                  dout,
  output logic                        write,
  output logic [CHANNELS-1:0]         busy,
  output logic [CHANNELS-1:0]         done,
  output logic [idx_w(CHANNELS)-1:0]  active
);
  localparam int IW = idx_w(CHANNELS);
  localparam int CW = LW + BLK_SHIFT;
  state_e state_q, state_d;
  logic [CHANNELS-1:0] ctrl_q, pending_q, pending_d, done_q, done_d;
  logic [IW-1:0] active_q, active_d, last_q, last_d, gnt_idx;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d, addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] dout_q, dout_d;
  logic write_q, write_d, fill_mode_q, fill_mode_d, gnt_valid;
  logic [1:0] ch_mode, eff_mode;
  logic swap, fill_sel;
  dma_rr_arb #(.N(CHANNELS), .IW(IW)) u_arb (
    .req(pending_q), .last(last_q), .valid(gnt_valid), .index(gnt_idx)
  );
  assign ch_mode  = mode[active_q*2 +: 2];
  assign eff_mode = ch_mode == 2'b11 ? MODE_COPY : ch_mode;
  assign swap     = eff_mode == MODE_SWAP;
  assign fill_sel = eff_mode == MODE_FILL;
`ifndef DMA_MULTI_FILL_EN
  logic unused_fill;
  assign unused_fill = ^{fill, fill_sel};
`endif
  always_comb begin
    busy = pending_q;
    for (int n = 0; n < CHANNELS; n++)
      if (state_q != IDLE && active_q == IW'(n)) busy[n] = 1'b1;
  end
  always_comb begin
    state_d = state_q;
    pending_d = pending_q | (ctrl & ~ctrl_q & ~busy);
    active_d = active_q;
    last_d = last_q;
    rd_d = rd_q;
    wr_d = wr_q;
    cnt_d = cnt_q;
    dout_d = dout_q;
    fill_mode_d = fill_mode_q;
    done_d = '0;
    if (rdy) begin
      case (state_q)
        IDLE: if (gnt_valid) begin
          state_d = START;
          active_d = gnt_idx;
          last_d = gnt_idx;
          pending_d[gnt_idx] = 1'b0;
        end
        START: begin
          cnt_d = CW'(length[active_q*LW +: LW]) << BLK_SHIFT;
          rd_d = swap ? dst_addr[active_q*AW +: AW] : src_addr[active_q*AW +: AW];
          wr_d = swap ? src_addr[active_q*AW +: AW] : dst_addr[active_q*AW +: AW];
`ifdef DMA_MULTI_FILL_EN
          fill_mode_d = fill_sel;
          if (fill_sel) dout_d = fill;
`else
          fill_mode_d = 1'b0;
`endif
          if (cnt_d == '0) begin
            state_d = IDLE;
            done_d[active_q] = 1'b1;
          end else state_d = fill_mode_d ? WRITE : READ;
        end
        READ: begin
          state_d = WRITE;
          dout_d = din;
        end
        default: begin
          rd_d = rd_q + AW'(1);
          wr_d = wr_q + AW'(1);
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = IDLE;
            done_d[active_q] = 1'b1;
          end else state_d = fill_mode_q ? WRITE : READ;
        end
      endcase
    end
    // Outputs are registered against the state being entered so they line up with it.
    addr_d = state_d == READ ? rd_d : state_d == WRITE ? wr_d : addr_q;
    write_d = state_d == WRITE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ctrl_q <= '0;
      pending_q <= '0;
      last_q <= IW'(CHANNELS - 1);
      active_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
      dout_q <= '0;
      write_q <= 1'b0;
      fill_mode_q <= 1'b0;
      done_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q <= ctrl;
      pending_q <= pending_d;
      last_q <= last_d;
      active_q <= active_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      dout_q <= dout_d;
      write_q <= write_d;
      fill_mode_q <= fill_mode_d;
      done_q <= done_d;
    end
  end
  assign addr = addr_q;
  assign dout = dout_q;
  assign write = write_q;
  assign done = done_q;
  assign active = active_q;
endmodule

// File: tb/tb_dma_multi.sv
// tb_dma_multi: scoreboard bench for dma_multi; expected writes/dones are queued by stimulus, popped by a monitor.
module tb_dma_multi;
  logic clk = 0, reset = 1, rdy = 1;
  logic [1:0] ctrl = '0;
  logic [31:0] src_addr = '0, dst_addr = '0;
  logic [15:0] length = '0;
  logic [3:0] mode = '0;
  logic [7:0] fill = '0, din, dout;
  logic [15:0] addr;
  logic write;
  logic [1:0] busy, done;
  logic [0:0] active;
  typedef struct {bit dn; logic [15:0] a; logic [7:0] d; logic [1:0] v;} ev_t;
  ev_t q[$];
  int total = 0, bad = 0, cyc = 0, wr_txn = 0, nwb = 0, done_cyc = 0;
  dma_multi dut (
    .clk(clk), .reset(reset), .rdy(rdy), .ctrl(ctrl), .src_addr(src_addr), .dst_addr(dst_addr),
    .length(length), .mode(mode), .fill(fill), .din(din), .addr(addr), .dout(dout),
    .write(write), .busy(busy), .done(done), .active(active)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] memf(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction
  assign din = memf(addr);
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    ev_t e;
    if (!reset) begin
      if (busy != 0 && !write) nwb++;
      if (write && rdy) begin
        wr_txn++;
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected none", addr, dout);
        end else begin
          e = q.pop_front();
          chk("wr_kind", 0, 32'(e.dn));
          chk("wr_addr", 32'(addr), 32'(e.a));
          chk("wr_data", 32'(dout), 32'(e.d));
        end
      end
      if (done != 0) begin
        done_cyc = cyc;
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got %0h expected none", done);
        end else begin
          e = q.pop_front();
          chk("done_kind", 1, 32'(e.dn));
          chk("done_vec", 32'(done), 32'(e.v));
        end
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic cfg(input int ch, input logic [15:0] s, input logic [15:0] d, input logic [7:0] len, input logic [1:0] m);
    src_addr[ch*16 +: 16] = s;
    dst_addr[ch*16 +: 16] = d;
    length[ch*8 +: 8] = len;
    mode[ch*2 +: 2] = m;
  endtask
  task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
    ev_t e;
    e.dn = 0; e.a = a; e.d = d; e.v = '0;
    q.push_back(e);
  endtask
  task automatic push_done(input logic [1:0] v);
    ev_t e;
    e.dn = 1; e.a = '0; e.d = '0; e.v = v;
    q.push_back(e);
  endtask
  task automatic push_copy(input logic [15:0] s, input logic [15:0] d, input int n, input logic [1:0] v);
    for (int i = 0; i < n; i++) push_wr(16'(d + i), memf(16'(s + i)));
    push_done(v);
  endtask
  task automatic pulse(input logic [1:0] m);
    ctrl = ctrl | m;
    tick(1);
    ctrl = ctrl & ~m;
  endtask
  task automatic wait_idle(input string nm, input int budget, input bit tog);
    int n;
    n = 0;
    do begin
      tick(1);
      if (tog) rdy = ~rdy;
      n++;
    end while (!(busy == 0 && q.size() == 0) && n < budget);
    rdy = 1;
    chk({nm, "_finish"}, 32'(busy == 0 && q.size() == 0), 1);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    int s, w0, base;
    bit hit;
    tick(3);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_write", 32'(write), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_active", 32'(active), 0);
    reset = 0;
    tick(2);
    // Basic copy, plus a re-pulse while busy that must be ignored.
    cfg(0, 16'h1000, 16'h2000, 8'd1, 2'b00);
    push_copy(16'h1000, 16'h2000, 16, 2'b01);
    nwb = 0;
    pulse(2'b01);
    tick(10);
    pulse(2'b01);
    wait_idle("copy", 200, 0);
    chk("copy_nonwrite_cycles", 32'(nwb), 18);
    tick(5);
    chk("copy_no_restart", 32'(busy), 0);
    // Fill with address wrap (copy fallback when fill is not compiled in).
    cfg(0, 16'h0500, 16'hFFF8, 8'd1, 2'b10);
    fill = 8'hA5;
    nwb = 0;
`ifdef DMA_MULTI_FILL_EN
    for (int i = 0; i < 16; i++) push_wr(16'(16'hFFF8 + i), 8'hA5);
    push_done(2'b01);
    s = 2;
`else
    push_copy(16'h0500, 16'hFFF8, 16, 2'b01);
    s = 18;
`endif
    pulse(2'b01);
    wait_idle("fill", 200, 0);
    chk("fill_nonwrite_cycles", 32'(nwb), 32'(s));
    // Swap-direction copy on ch1 with rdy toggling.
    cfg(1, 16'h2200, 16'h33F8, 8'd1, 2'b01);
    push_copy(16'h33F8, 16'h2200, 16, 2'b10);
    pulse(2'b10);
    wait_idle("rdy_toggle", 300, 1);
    // Simultaneous requests after reset: ch0 first.
    reset = 1;
    tick(2);
    reset = 0;
    cfg(0, 16'h1000, 16'h2000, 8'd1, 2'b00);
    cfg(1, 16'h3000, 16'h4000, 8'd1, 2'b00);
    push_copy(16'h1000, 16'h2000, 16, 2'b01);
    push_copy(16'h3000, 16'h4000, 16, 2'b10);
    pulse(2'b11);
    wait_idle("pair1", 300, 0);
    // Zero length on ch0: done two cycles after grant, no write.
    cfg(0, 16'h1000, 16'h2000, 8'd0, 2'b00);
    push_done(2'b01);
    w0 = wr_txn;
    s = cyc;
    pulse(2'b01);
    wait_idle("len0", 20, 0);
    chk("len0_done_latency", 32'(done_cyc - s), 3);
    chk("len0_no_write", 32'(wr_txn), 32'(w0));
    // ch0 served last, so a simultaneous pair now goes ch1 first.
    cfg(0, 16'h1000, 16'h2000, 8'd1, 2'b00);
    push_copy(16'h3000, 16'h4000, 16, 2'b10);
    push_copy(16'h1000, 16'h2000, 16, 2'b01);
    pulse(2'b11);
    wait_idle("pair2", 300, 0);
    // Reset during the 5th write aborts without done.
    for (int i = 0; i < 4; i++) push_wr(16'(16'h2000 + i), memf(16'(16'h1000 + i)));
    base = wr_txn;
    hit = 0;
    pulse(2'b01);
    for (int i = 0; i < 100 && !hit; i++) begin
      tick(1);
      if (write && wr_txn - base == 4) hit = 1;
    end
    chk("abort_reached_5th_write", 32'(hit), 1);
    reset = 1;
    tick(1);
    chk("abort_write", 32'(write), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_queue", 32'(q.size()), 0);
    q.delete();
    reset = 0;
    tick(1);
    chk("abort_no_late_done", 32'(done), 0);
    push_copy(16'h1000, 16'h2000, 16, 2'b01);
    pulse(2'b01);
    wait_idle("restart", 200, 0);
    tick(3);
    chk("queue_empty", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
